// File: rtl/alu_sequencer_fsm.sv
// Multicycle control FSM sequencing ALU, register file, PC/IR and memory port for one instruction.
// Optional illegal-instruction trap enabled by defining ALU_SEQ_ILLEGAL_TRAP_EN.
module alu_sequencer_fsm #(
  parameter int MEM_WAIT_MAX = 16,
  parameter int FUNC_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              mem_ready,
  input  logic              alu_zero,
  output logic              ir_write,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic              mem_read,
  output logic              mem_write,
  output logic              iord,
  output logic [FUNC_W-1:0] alu_func,
  output logic [1:0]        alu_typ,
  output logic              reg_write,
  output logic [1:0]        wb_sel,
  output logic              illegal,
  output logic              timeout,
  output logic [2:0]        state_o
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_ALUWB  = 3'd3,
    S_MEMACC = 3'd4,
    S_MEMWB  = 3'd5,
    S_BRANCH = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic [FUNC_W-1:0] func_q;
  logic [1:0]        typ_q;
  logic              stop_q;

  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[31-FUNC_W:3];

  // Instruction class decode from the latched IR fields
  logic   is_i, is_j, is_lw, is_sw, is_beq, is_legal;
  state_t done_state;

  always_comb begin
    is_j       = (typ_q == 2'b11);
    is_i       = (typ_q == 2'b10);
    is_lw      = is_i && (func_q == FUNC_W'(2));
    is_sw      = is_i && (func_q == FUNC_W'(3));
    is_beq     = is_i && (func_q == FUNC_W'(4));
    is_legal   = is_j || (is_i && (func_q <= FUNC_W'(4))) ||
                 (!is_i && !is_j && (func_q <= FUNC_W'(2)));
    done_state = stop_q ? S_HALT : S_FETCH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      func_q    <= '0;
      typ_q     <= 2'b00;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      if (state_q == S_FETCH && mem_ready) begin
        func_q <= instr[31 -: FUNC_W];
        typ_q  <= instr[2:1];
        stop_q <= instr[0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    iord      = 1'b0;
    alu_func  = '0;
    alu_typ   = 2'b00;
    reg_write = 1'b0;
    wb_sel    = 2'b00;

    // Keep the ALU inputs stable for every state that consumes its registered result
    if (state_q inside {S_EXEC, S_ALUWB, S_MEMACC, S_MEMWB, S_BRANCH}) begin
      alu_func = func_q;
      alu_typ  = is_beq ? 2'b00 : typ_q;
    end

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_j) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          state_d  = done_state;
        end else if (!is_legal) begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
          illegal_d = 1'b1;
          state_d   = S_HALT;
`else
          state_d   = done_state;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_lw || is_sw) state_d = S_MEMACC;
        else if (is_beq)    state_d = S_BRANCH;
        else                state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = done_state;
      end
      S_MEMACC: begin
        iord      = 1'b1;
        mem_read  = is_lw;
        mem_write = is_sw;
        if (mem_ready) state_d = is_lw ? S_MEMWB : done_state;
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        wb_sel    = 2'b01;
        state_d   = done_state;
      end
      S_BRANCH: begin
        if (alu_zero) begin
          pc_write = 1'b1;
          pc_src   = 2'b01;
        end
        state_d = done_state;
      end
      default: state_d = S_HALT;
    endcase

    // A late mem_ready on the final permitted cycle still completes the access
    if ((state_q == S_FETCH || state_q == S_MEMACC) && !mem_ready) begin
      if (wait_q == CNT_W'(MEM_WAIT_MAX - 1)) begin
        timeout_d = 1'b1;
        state_d   = S_HALT;
      end else begin
        wait_d = wait_q + CNT_W'(1);
      end
    end

    if (rst) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'b00;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      iord      = 1'b0;
      alu_func  = '0;
      alu_typ   = 2'b00;
      reg_write = 1'b0;
      wb_sel    = 2'b00;
    end
  end

  assign illegal = rst ? 1'b0 : illegal_q;
  assign timeout = rst ? 1'b0 : timeout_q;
  assign state_o = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_alu_sequencer_fsm.sv
// Directed-vector bench for alu_sequencer_fsm with hand-computed per-cycle expectations.
module tb_alu_sequencer_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        alu_zero;
  logic        ir_write, pc_write, mem_read, mem_write, iord, reg_write;
  logic        illegal, timeout;
  logic [1:0]  pc_src, alu_typ, wb_sel;
  logic [4:0]  alu_func;
  logic [2:0]  state_o;

  int n_chk  = 0;
  int n_pass = 0;

  alu_sequencer_fsm #(.MEM_WAIT_MAX(16), .FUNC_W(5)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .alu_func(alu_func), .alu_typ(alu_typ),
    .reg_write(reg_write), .wb_sel(wb_sel), .illegal(illegal), .timeout(timeout),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  logic [9:0] ctrl;
  assign ctrl = {ir_write, pc_write, pc_src, mem_read, mem_write, iord, reg_write, wb_sel};

  function automatic logic [9:0] cv(input logic ir, pw, input logic [1:0] ps,
                                    input logic mr, mw, io, rw, input logic [1:0] wb);
    return {ir, pw, ps, mr, mw, io, rw, wb};
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] f, input logic [1:0] t, input logic s);
    return {f, 24'd0, t, s};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one cycle's state and control vector, then advance a clock
  task automatic cyc(input string tag, input logic [2:0] st, input logic [9:0] c);
    #1;
    check({tag, " state"}, 32'(state_o), 32'(st));
    check({tag, " ctrl"}, 32'(ctrl), 32'(c));
    tick();
  endtask

  localparam logic [9:0] FETCH_OK   = 10'b11_00_1_0_0_0_00;
  localparam logic [9:0] FETCH_WAIT = 10'b00_00_1_0_0_0_00;
  localparam logic [9:0] IDLE       = 10'b00_00_0_0_0_0_00;

  initial begin
    rst = 1'b1; instr = 32'd0; mem_ready = 1'b1; alu_zero = 1'b0;
    tick(); tick();
    #1;
    check("rst state", 32'(state_o), 32'd0);
    check("rst ctrl", 32'(ctrl), 32'd0);
    check("rst flags", {30'd0, illegal, timeout}, 32'd0);
    rst = 1'b0;

    // ADD R-type: 0,1,2,3 then FETCH
    instr = mk(5'd1, 2'b00, 1'b0);
    cyc("add f", 3'd0, FETCH_OK);
    cyc("add d", 3'd1, IDLE);
    check("add func", 32'(alu_func), 32'd1);
    check("add typ", 32'(alu_typ), 32'd0);
    cyc("add e", 3'd2, IDLE);
    cyc("add wb", 3'd3, cv(0, 0, 2'b00, 0, 0, 0, 1, 2'b00));

    // LW with three wait cycles in MEMACC
    instr = mk(5'd2, 2'b10, 1'b0);
    cyc("lw f", 3'd0, FETCH_OK);
    cyc("lw d", 3'd1, IDLE);
    check("lw func", 32'(alu_func), 32'd2);
    check("lw typ", 32'(alu_typ), 32'd2);
    cyc("lw e", 3'd2, IDLE);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw wait", 3'd4, cv(0, 0, 2'b00, 1, 0, 1, 0, 2'b00));
    mem_ready = 1'b1;
    cyc("lw acc", 3'd4, cv(0, 0, 2'b00, 1, 0, 1, 0, 2'b00));
    cyc("lw wb", 3'd5, cv(0, 0, 2'b00, 0, 0, 0, 1, 2'b01));

    // BEQ taken, then not taken
    instr = mk(5'd4, 2'b10, 1'b0);
    alu_zero = 1'b1;
    cyc("beq1 f", 3'd0, FETCH_OK);
    cyc("beq1 d", 3'd1, IDLE);
    cyc("beq1 e", 3'd2, IDLE);
    cyc("beq1 br", 3'd6, cv(0, 1, 2'b01, 0, 0, 0, 0, 2'b00));
    alu_zero = 1'b0;
    cyc("beq0 f", 3'd0, FETCH_OK);
    cyc("beq0 d", 3'd1, IDLE);
    cyc("beq0 e", 3'd2, IDLE);
    cyc("beq0 br", 3'd6, IDLE);

    // J then ADD with stop -> HALT held
    instr = mk(5'd0, 2'b11, 1'b0);
    cyc("j f", 3'd0, FETCH_OK);
    cyc("j d", 3'd1, cv(0, 1, 2'b10, 0, 0, 0, 0, 2'b00));
    instr = mk(5'd1, 2'b00, 1'b1);
    cyc("adds f", 3'd0, FETCH_OK);
    cyc("adds d", 3'd1, IDLE);
    cyc("adds e", 3'd2, IDLE);
    cyc("adds wb", 3'd3, cv(0, 0, 2'b00, 0, 0, 0, 1, 2'b00));
    for (int i = 0; i < 20; i++) cyc("halt", 3'd7, IDLE);

    // Timeout after 16 FETCH cycles without mem_ready
    rst = 1'b1; tick(); rst = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) cyc("to wait", 3'd0, FETCH_WAIT);
    #1;
    check("to state", 32'(state_o), 32'd7);
    check("to flag", 32'(timeout), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    check("to cleared", 32'(timeout), 32'd0);

    // mem_ready on the 16th cycle wins
    instr = mk(5'd1, 2'b00, 1'b0);
    for (int i = 0; i < 15; i++) cyc("nto wait", 3'd0, FETCH_WAIT);
    mem_ready = 1'b1;
    cyc("nto f", 3'd0, FETCH_OK);
    check("nto flag", 32'(timeout), 32'd0);
    cyc("nto d", 3'd1, IDLE);
    cyc("nto e", 3'd2, IDLE);
    cyc("nto wb", 3'd3, cv(0, 0, 2'b00, 0, 0, 0, 1, 2'b00));

    // SW abandoned by reset in MEMACC
    instr = mk(5'd3, 2'b10, 1'b0);
    cyc("sw f", 3'd0, FETCH_OK);
    cyc("sw d", 3'd1, IDLE);
    cyc("sw e", 3'd2, IDLE);
    mem_ready = 1'b0;
    cyc("sw acc", 3'd4, cv(0, 0, 2'b00, 0, 1, 1, 0, 2'b00));
    rst = 1'b1;
    #1;
    check("sw rst ctrl", 32'(ctrl), 32'd0);
    tick();
    rst = 1'b0;
    cyc("sw refetch", 3'd0, FETCH_WAIT);
    mem_ready = 1'b1;

    // Undefined func=7 on R-type
    instr = mk(5'd7, 2'b00, 1'b0);
    cyc("ill f", 3'd0, FETCH_OK);
    cyc("ill d", 3'd1, IDLE);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    cyc("ill halt", 3'd7, IDLE);
    check("ill flag", 32'(illegal), 32'd1);
`else
    instr = mk(5'd1, 2'b00, 1'b0);
    cyc("ill next", 3'd0, FETCH_OK);
    check("ill flag", 32'(illegal), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
